// File: rtl/dawson64_pkg.sv
// Shared types and constants for the Dawson 64-bit stb/ack responder.
// Holds the responder FSM encoding, datapath width, timeout NaN and default watchdog depth.
package dawson64_pkg;

    localparam int DAWSON_WIDTH = 64;
    localparam int DAWSON_TIMEOUT_CYCLES = 1024;
    localparam logic [63:0] DAWSON_QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_GET_B,
        ST_START,
        ST_BUSY,
        ST_PUT_Z
    } dawson_state_e;

endpackage

// File: rtl/dawson64_resp_watchdog.sv
// BUSY-phase watchdog: cleared by load_i, counts while en_i, flags the TIMEOUT_CYCLES-th cycle.
// Latency: expire_o is combinational on the final counted cycle; no backpressure.
module dawson64_resp_watchdog
    import dawson64_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DAWSON_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count starts at 0 on the first BUSY cycle, so LAST marks the final allowed cycle.
    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/dawson64_resp_if.sv
// Dawson stb/ack responder: accepts A then B, pulses core_start, returns core result on Z.
// Latency: B transfer -> core_start 1 cycle; core_done -> output_z_stb 1 cycle; 5-cycle minimum.
// Backpressure: Z held until output_z_ack, no A ack meanwhile; DAWSON_RESP_TIMEOUT_EN adds BUSY watchdog.
module dawson64_resp_if
    import dawson64_pkg::*;
#(
    parameter int WIDTH          = DAWSON_WIDTH,
    parameter int TIMEOUT_CYCLES = DAWSON_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_b_stb,
    output logic             input_b_ack,
    output logic [WIDTH-1:0] output_z,
    output logic             output_z_stb,
    input  logic             output_z_ack,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic             core_start,
    input  logic [WIDTH-1:0] core_result,
    input  logic             core_done,
    output logic             busy,
    output logic             timeout_err
);

    dawson_state_e    state_q, state_d;
    logic [WIDTH-1:0] core_a_q, core_a_d;
    logic [WIDTH-1:0] core_b_q, core_b_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             z_stb_q, z_stb_d;
    logic             terr_q, terr_d;
    logic             a_ack_q, b_ack_q, start_q, busy_q;
    logic             wd_expire;

`ifdef DAWSON_RESP_TIMEOUT_EN
    dawson64_resp_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .load_i   (state_q == ST_START),
        .en_i     (state_q == ST_BUSY),
        .expire_o (wd_expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        core_a_d = core_a_q;
        core_b_d = core_b_q;
        z_d      = z_q;
        z_stb_d  = z_stb_q;
        terr_d   = terr_q;
        unique case (state_q)
            ST_GET_A: begin
                if (a_ack_q && input_a_stb) begin
                    core_a_d = input_a;
                    state_d  = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (b_ack_q && input_b_stb) begin
                    core_b_d = input_b;
                    state_d  = ST_START;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                // A real result on the expiry edge takes priority over the timeout.
                if (core_done) begin
                    z_d     = core_result;
                    z_stb_d = 1'b1;
                    state_d = ST_PUT_Z;
                end else if (wd_expire) begin
                    z_d     = WIDTH'(DAWSON_QNAN);
                    z_stb_d = 1'b1;
                    terr_d  = 1'b1;
                    state_d = ST_PUT_Z;
                end
            end
            ST_PUT_Z: begin
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = ST_GET_A;
                end
            end
            default: state_d = ST_GET_A;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_GET_A;
            core_a_q <= '0;
            core_b_q <= '0;
            z_q      <= '0;
            z_stb_q  <= 1'b0;
            terr_q   <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            core_a_q <= core_a_d;
            core_b_q <= core_b_d;
            z_q      <= z_d;
            z_stb_q  <= z_stb_d;
            terr_q   <= terr_d;
            a_ack_q  <= (state_d == ST_GET_A);
            b_ack_q  <= (state_d == ST_GET_B);
            start_q  <= (state_d == ST_START);
            busy_q   <= (state_d != ST_GET_A);
        end
    end

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;
    assign core_a       = core_a_q;
    assign core_b       = core_b_q;
    assign core_start   = start_q;
    assign busy         = busy_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_dawson64_resp_if.sv
// Scoreboard bench for dawson64_resp_if: directed transactions, queue-based Z and core-operand checks.
module tb_dawson64_resp_if;
    import dawson64_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] input_a, input_b, output_z, core_a, core_b, core_result;
    logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
    logic        output_z_stb, output_z_ack, core_start, core_done, busy, timeout_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_start = 0;
    int core_lat = 0;
    int starts_before;
    int zc;
    logic [63:0]  exp_q[$];
    logic [127:0] exp_ab_q[$];
    int           z_cyc[$];
    logic         prev_hold = 1'b0;
    logic         prev_start = 1'b0;
    logic [63:0]  prev_z = '0;

    dawson64_resp_if #(
        .WIDTH(64),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
        .core_a(core_a), .core_b(core_b), .core_start(core_start),
        .core_result(core_result), .core_done(core_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // which: 0 a_ack, 1 b_ack, 2 z_stb, 3 z transfer, 4 core_start. Returns at the negedge it is seen.
    task automatic wait_for(input int which, input string name);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            case (which)
                0: hit = input_a_ack;
                1: hit = input_b_ack;
                2: hit = output_z_stb;
                3: hit = output_z_stb && output_z_ack;
                default: hit = core_start;
            endcase
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL wait_%s actual=no_event required=event", name);
        end
    endtask

    task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input logic [63:0] z,
                           input bit expect_z, input int pre);
        if (expect_z) exp_q.push_back(z);
        exp_ab_q.push_back({a, b});
        input_a = a;
        input_b = b;
        input_b_stb = 1'b1;
        for (int i = 0; i < pre; i++) begin
            @(negedge clk);
            chk("b_ack_early", input_b_ack, 0);
        end
        if (pre > 0) begin
            @(posedge clk); #1;
        end
        input_a_stb = 1'b1;
        wait_for(0, "a_ack");
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        wait_for(1, "b_ack");
        @(posedge clk); #1;
        input_b_stb = 1'b0;
    endtask

    // Core model: result = a + b, done for one cycle core_lat cycles after start (0 = never).
    initial begin
        core_done = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (!rst && core_start && core_lat > 0) begin
                logic [63:0] r;
                r = core_a + core_b;
                repeat (core_lat) @(posedge clk);
                #1;
                core_done = 1'b1;
                core_result = r;
                @(posedge clk); #1;
                core_done = 1'b0;
                core_result = '0;
            end
        end
    end

    // Monitor: scoreboard pops, hold stability, ack exclusivity, start pulse checks.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("ack_exclusive", input_a_ack && (input_b_ack || output_z_stb), 0);
                if (prev_hold) begin
                    chk("z_stb_held", output_z_stb, 1);
                    chk("z_held", output_z, prev_z);
                end
                if (output_z_stb && output_z_ack) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL z_unexpected actual=%h required=none", output_z);
                    end else begin
                        chk("z_data", output_z, exp_q.pop_front());
                    end
                    z_cyc.push_back(cyc);
                end
                prev_hold = output_z_stb && !output_z_ack;
                prev_z = output_z;
                if (core_start) begin
                    logic [127:0] ab;
                    chk("core_start_single", prev_start, 0);
                    if (exp_ab_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL start_unexpected actual=%h required=none", core_a);
                    end else begin
                        ab = exp_ab_q.pop_front();
                        chk("core_a", core_a, ab[127:64]);
                        chk("core_b", core_b, ab[63:0]);
                    end
                    n_start++;
                end
                prev_start = core_start;
            end else begin
                prev_hold = 1'b0;
                prev_start = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_ack"}, input_a_ack, 0);
        chk({tag, "_b_ack"}, input_b_ack, 0);
        chk({tag, "_z_stb"}, output_z_stb, 0);
        chk({tag, "_z"}, output_z, 0);
        chk({tag, "_start"}, core_start, 0);
        chk({tag, "_core_a"}, core_a, 0);
        chk({tag, "_core_b"}, core_b, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_terr"}, timeout_err, 0);
    endtask

    initial begin
        rst = 1'b1;
        input_a = '0; input_b = '0;
        input_a_stb = 1'b0; input_b_stb = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic: 1 + 2 with a 2-cycle core.
        output_z_ack = 1'b1;
        core_lat = 2;
        run_txn(64'd1, 64'd2, 64'd3, 1'b1, 0);
        wait_for(3, "z_basic");
        @(negedge clk);
        chk("a_ack_after_z", input_a_ack, 1);
        chk("basic_starts", n_start, 1);

        // Backpressure: Z held 5 cycles with ack low.
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        core_lat = 1;
        run_txn(64'h10, 64'h20, 64'h30, 1'b1, 0);
        wait_for(2, "z_bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stb", output_z_stb, 1);
            chk("bp_z", output_z, 64'h30);
            chk("bp_a_ack", input_a_ack, 0);
        end
        @(posedge clk); #1;
        output_z_ack = 1'b1;
        wait_for(3, "z_bp_xfer");

        // Early B stb during GET_A waits for the A transfer.
        @(posedge clk); #1;
        run_txn(64'd5, 64'd7, 64'd12, 1'b1, 3);
        wait_for(3, "z_ooo");

        // Reset in BUSY; the late core_done must be ignored.
        @(posedge clk); #1;
        core_lat = 6;
        starts_before = n_start;
        run_txn(64'hAA, 64'h55, 64'h0, 1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_a_ack", input_a_ack, 1);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_z_stb", output_z_stb, 0);
        end
        chk("rst_starts", n_start - starts_before, 1);

        // Back-to-back with a 1-cycle core: 5-cycle cadence.
        @(posedge clk); #1;
        core_lat = 1;
        starts_before = n_start;
        zc = z_cyc.size();
        run_txn(64'd1, 64'd2, 64'd3, 1'b1, 0);
        run_txn(64'd4, 64'd5, 64'd9, 1'b1, 0);
        wait_for(3, "z_b2b");
        @(negedge clk);
        chk("b2b_z_count", z_cyc.size() - zc, 2);
        if (z_cyc.size() >= zc + 2) chk("b2b_cadence", z_cyc[zc+1] - z_cyc[zc], 5);
        chk("b2b_starts", n_start - starts_before, 2);

`ifdef DAWSON_RESP_TIMEOUT_EN
        // Core never answers: NaN after TO BUSY cycles, sticky error.
        @(posedge clk); #1;
        core_lat = 0;
        output_z_ack = 1'b0;
        run_txn(64'd1, 64'd2, DAWSON_QNAN, 1'b1, 0);
        for (int i = 0; i <= TO; i++) begin
            @(negedge clk);
            chk("to_stb_low", output_z_stb, 0);
        end
        @(negedge clk);
        chk("to_stb", output_z_stb, 1);
        chk("to_z", output_z, DAWSON_QNAN);
        chk("to_err", timeout_err, 1);
        @(posedge clk); #1;
        output_z_ack = 1'b1;
        wait_for(3, "z_to");
        repeat (2) @(negedge clk);
        chk("to_err_sticky", timeout_err, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("to_err_cleared", timeout_err, 0);
`else
        @(negedge clk);
        chk("terr_tied", timeout_err, 0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
